// File: rtl/seg7_scan_driver_if.sv
// Load-side bundle for seg7_scan_driver: strobe, packed digits, dp/blank masks
// and the leading-zero level. master = producer, slave = display driver.
interface seg7_scan_driver_if #(
    parameter int DIGITS = 4
);
    logic                  load;
    logic [4*DIGITS-1:0]   data_in;
    logic [DIGITS-1:0]     dp_in;
    logic [DIGITS-1:0]     blank_in;
    logic                  lz_en;

    modport master (
        output load, data_in, dp_in, blank_in, lz_en
    );

    modport slave (
        input load, data_in, dp_in, blank_in, lz_en
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment scan driver with tear-free updates.
// Ports: clk, rst_n, bus (load/data_in/dp_in/blank_in/lz_en), anodes,
// cathodes {g..a}, dp (all active-low, registered), frame_done pulse.
module seg7_scan_driver #(
    parameter int DIGITS = 4,
    parameter int DIV    = 50000,
    parameter int GUARD  = 500,
    parameter bit HEX    = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    seg7_scan_driver_if.slave bus,
    output logic [DIGITS-1:0] anodes,
    output logic [6:0]        cathodes,
    output logic              dp,
    output logic              frame_done
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);
    localparam logic [CW-1:0] GUARD_C = CW'(GUARD);

    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic                  pend;
    logic [4*DIGITS-1:0]   pend_data, act_data;
    logic [DIGITS-1:0]     pend_dp, act_dp;
    logic [DIGITS-1:0]     pend_blank, act_blank;

    logic                  slot_end, wrap;
    logic [DIGITS-1:0]     supp;
    logic [3:0]            nib;
    logic                  blk, sup, dpa;
    logic [DIGITS-1:0]     anode_nxt;
    logic [6:0]            seg_nxt;
    logic                  dp_nxt;

    function automatic logic [6:0] decode(input logic [3:0] n);
        logic [6:0] s;
        unique case (n)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = HEX ? 7'b0001000 : 7'h7F;
            4'hB: s = HEX ? 7'b0000011 : 7'h7F;
            4'hC: s = HEX ? 7'b1000110 : 7'h7F;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            4'hF: s = HEX ? 7'b0001110 : 7'h7F;
        endcase
        return s;
    endfunction

    assign slot_end = (cnt == CNT_MAX);
    assign wrap     = slot_end && (idx == IDX_MAX);

    // Zero run from the top digit down; a blanked digit keeps the run
    // going unless its nibble is non-zero. Digit 0 always shows.
    always_comb begin
        logic run;
        run  = bus.lz_en;
        supp = '0;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            run     = run && (act_data[4*k +: 4] == 4'h0);
            supp[k] = run;
        end
    end

    always_comb begin
        nib = 4'h0;
        blk = 1'b1;
        sup = 1'b0;
        dpa = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx == IW'(k)) begin
                nib = act_data[4*k +: 4];
                blk = act_blank[k];
                sup = supp[k];
                dpa = act_dp[k];
            end
        end
    end

    // A force-blanked digit also keeps its anode off, so the reset
    // state (all blank) leaves the whole display dark.
    always_comb begin
        anode_nxt = '1;
        for (int k = 0; k < DIGITS; k++) begin
            anode_nxt[k] = !((idx == IW'(k)) && (cnt >= GUARD_C)
                             && !act_blank[k]);
        end
        seg_nxt = (blk || sup) ? 7'h7F : decode(nib);
        dp_nxt  = blk ? 1'b1 : ~dpa;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            idx        <= '0;
            pend       <= 1'b0;
            pend_data  <= '0;
            pend_dp    <= '0;
            pend_blank <= '0;
            act_data   <= '1;
            act_dp     <= '0;
            act_blank  <= '1;
            anodes     <= '1;
            cathodes   <= 7'h7F;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            cnt <= slot_end ? '0 : cnt + 1'b1;
            if (slot_end) begin
                idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
            end
            if (bus.load) begin
                pend_data  <= bus.data_in;
                pend_dp    <= bus.dp_in;
                pend_blank <= bus.blank_in;
            end
            // A load on the wrap cycle bypasses the pending set.
            if (wrap && (bus.load || pend)) begin
                act_data  <= bus.load ? bus.data_in  : pend_data;
                act_dp    <= bus.load ? bus.dp_in    : pend_dp;
                act_blank <= bus.load ? bus.blank_in : pend_blank;
                pend      <= 1'b0;
            end else if (bus.load) begin
                pend <= 1'b1;
            end
            anodes     <= anode_nxt;
            cathodes   <= seg_nxt;
            dp         <= dp_nxt;
            frame_done <= wrap;
        end
    end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: HEX=0 and HEX=1 instances share one
// load bus; DIGITS=4, DIV=4, GUARD=1, so a frame is 16 cycles.
module tb_seg7_scan_driver;
    localparam int DIGITS = 4;
    localparam int DIV    = 4;
    localparam int GUARD  = 1;

    typedef struct packed {
        logic [15:0]     data;
        logic [3:0]      dpm;
        logic [3:0]      blank;
        logic            lz;
        logic [3:0][6:0] c0;
        logic [3:0][6:0] c1;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [3:0] an0, an1;
    logic [6:0] ca0, ca1;
    logic dp0, dp1, fd0, fd1;
    int checks = 0;
    int errors = 0;
    vec_t tbl [6];
    vec_t dark;

    seg7_scan_driver_if #(.DIGITS(DIGITS)) bus ();

    seg7_scan_driver #(
        .DIGITS(DIGITS), .DIV(DIV), .GUARD(GUARD), .HEX(1'b0)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .anodes(an0), .cathodes(ca0), .dp(dp0), .frame_done(fd0)
    );

    seg7_scan_driver #(
        .DIGITS(DIGITS), .DIV(DIV), .GUARD(GUARD), .HEX(1'b1)
    ) u_hex (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .anodes(an1), .cathodes(ca1), .dp(dp1), .frame_done(fd1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int j,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s j=%0d: got %h expected %h", name, j, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " anodes"}, 0, 32'(an0), 32'hF);
        chk({tag, " cathodes"}, 0, 32'(ca0), 32'h7F);
        chk({tag, " dp"}, 0, 32'(dp0), 32'h1);
        chk({tag, " frame_done"}, 0, 32'(fd0), 32'h0);
        chk({tag, " hex anodes"}, 0, 32'(an1), 32'hF);
        chk({tag, " hex cathodes"}, 0, 32'(ca1), 32'h7F);
    endtask

    task automatic do_load(input vec_t v);
        bus.load     = 1'b1;
        bus.data_in  = v.data;
        bus.dp_in    = v.dpm;
        bus.blank_in = v.blank;
        bus.lz_en    = v.lz;
    endtask

    // Sample j of a frame (0..15): digit j/4, slot cycle j%4.
    task automatic check_sample(input vec_t v, input int j);
        int d, c;
        logic [3:0] an_exp;
        logic dp_exp;
        @(negedge clk);
        d = j / 4;
        c = j % 4;
        an_exp = (c < GUARD || v.blank[d]) ? 4'hF : ~(4'b0001 << d);
        dp_exp = ~(v.dpm[d] & ~v.blank[d]);
        chk("anodes", j, 32'(an0), 32'(an_exp));
        chk("cathodes", j, 32'(ca0), 32'(v.c0[d]));
        chk("dp", j, 32'(dp0), 32'(dp_exp));
        chk("frame_done", j, 32'(fd0), 32'(j == 15));
        chk("hex anodes", j, 32'(an1), 32'(an_exp));
        chk("hex cathodes", j, 32'(ca1), 32'(v.c1[d]));
        chk("hex dp", j, 32'(dp1), 32'(dp_exp));
    endtask

    task automatic wait_frame();
        int n;
        n = 0;
        while (!fd0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!fd0) begin
            errors++;
            $display("FAIL wait_frame: frame_done=%b after %0d cycles, expected 1",
                     fd0, n);
        end
    endtask

    task automatic check_frame(input vec_t v);
        wait_frame();
        for (int j = 0; j < 16; j++) begin
            check_sample(v, j);
        end
    endtask

    initial begin
        logic [6:0] b;
        b = 7'h7F;
        dark = '{data: 16'hFFFF, dpm: 4'h0, blank: 4'hF, lz: 1'b0,
                 c0: {4{b}}, c1: {4{b}}};
        tbl[0] = '{data: 16'h1234, dpm: 4'b0100, blank: 4'h0, lz: 1'b0,
            c0: {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001},
            c1: {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}};
        tbl[1] = '{data: 16'h0070, dpm: 4'h0, blank: 4'h0, lz: 1'b1,
            c0: {b, b, 7'b1111000, 7'b1000000},
            c1: {b, b, 7'b1111000, 7'b1000000}};
        tbl[2] = '{data: 16'h0000, dpm: 4'h0, blank: 4'h0, lz: 1'b1,
            c0: {b, b, b, 7'b1000000},
            c1: {b, b, b, 7'b1000000}};
        tbl[3] = '{data: 16'hABCD, dpm: 4'h0, blank: 4'h0, lz: 1'b0,
            c0: {b, b, b, 7'b0100001},
            c1: {7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001}};
        tbl[4] = '{data: 16'h0305, dpm: 4'b0101, blank: 4'b0100, lz: 1'b1,
            c0: {b, b, 7'b1000000, 7'b0010010},
            c1: {b, b, 7'b1000000, 7'b0010010}};
        tbl[5] = '{data: 16'hE0F8, dpm: 4'b1001, blank: 4'h0, lz: 1'b0,
            c0: {7'b0000110, 7'b1000000, b, 7'b0000000},
            c1: {7'b0000110, 7'b1000000, 7'b0001110, 7'b0000000}};

        bus.load     = 1'b0;
        bus.data_in  = '0;
        bus.dp_in    = '0;
        bus.blank_in = '0;
        bus.lz_en    = 1'b0;

        repeat (3) @(negedge clk);
        chk_reset("reset");
        rst_n = 1'b1;

        check_frame(dark);
        check_frame(dark);

        foreach (tbl[i]) begin
            do_load(tbl[i]);
            @(negedge clk);
            bus.load = 1'b0;
            check_frame(tbl[i]);
        end

        // Non-wrap load then a wrap-cycle load: the frame in flight keeps
        // the old set, and only the second value is ever displayed.
        do_load(tbl[1]);
        for (int j = 0; j < 16; j++) begin
            check_sample(tbl[5], j);
            if (j == 0) bus.load = 1'b0;
            if (j == 14) do_load(tbl[0]);
        end
        bus.load = 1'b0;
        check_frame(tbl[0]);
        check_frame(tbl[0]);

        // Reset in the middle of the digit-2 slot with a load pending.
        do_load(tbl[2]);
        for (int j = 0; j < 9; j++) begin
            check_sample(tbl[0], j);
            if (j == 0) bus.load = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        chk_reset("mid-frame reset");
        repeat (2) @(negedge clk);
        chk_reset("reset held");
        rst_n = 1'b1;
        check_frame(dark);
        check_frame(dark);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Parametrised, time-multiplexed seven-segment display driver for common-anode displays. It accepts a packed multi-digit value and scans the digits one at a time, refreshing each at a fixed rate. Decode is registered and active-low, with per-digit blanking, per-digit decimal points, optional leading-zero suppression, a hex/limited decode mode and a ghosting guard interval. It sits between the application datapath and the board's anode and cathode pins, and replaces the single-digit combinational decoder.

## Interface
- DIGITS, 4: number of multiplexed digits, 1..8.
- DIV, 50000: clock cycles each digit slot lasts, ≥ 2.
- GUARD, 500: cycles at the start of each slot with all anodes off; must be < DIV.
- HEX, 0: decode mode for codes 10..15. 1 = full hex A,b,C,d,E,F. 0 = 13→d, 14→E, 10/11/12/15→blank.
- clk  in  1  system clock.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- load  in  1  single-cycle strobe that captures data_in, dp_in and blank_in.
- data_in  in  4*DIGITS  BCD/hex nibbles; digit k = data_in[4k+3:4k]; digit 0 is least significant.
- dp_in  in  DIGITS  decimal point request per digit, 1 = lit.
- blank_in  in  DIGITS  per-digit force-blank, 1 = dark.
- lz_en  in  1  leading-zero suppression enable (level, sampled every cycle).
- anodes  out  DIGITS  active-low digit enables.
- cathodes  out  7  active-low segments {g,f,e,d,c,b,a}.
- dp  out  1  active-low decimal point.
- frame_done  out  1  one-cycle pulse when the scan wraps from digit DIGITS-1 to digit 0.

## Operation
- Registers:
  - slot counter `cnt`, 0..DIV-1.
  - digit index `idx`, 0..DIGITS-1.
  - pending set (data, dp, blank) and `pend` flag.
  - active set.
- Load:
  - load=1 writes the inputs into the pending set and sets `pend`.
  - Back-to-back loads: the last one wins.
- Tear-free update:
  - The active set changes only on the wrap cycle (cnt=DIV-1 and idx=DIGITS-1).
  - On that cycle, if load=1, the active set takes the inputs directly and `pend` clears.
  - Otherwise, if `pend`=1, the active set takes the pending set and `pend` clears.
  - Otherwise the active set holds.
- Scan:
  - `cnt` increments every cycle.
  - At DIV-1, `cnt` returns to 0 and `idx` increments.
  - `idx` wraps DIGITS-1→0, and frame_done is asserted on that same edge.
- Suppression:
  - With lz_en=1, digits DIGITS-1 downward whose active nibble is 0 are dark, up to the first non-zero nibble.
  - Digit 0 is never suppressed.
  - A force-blanked digit does not stop the zero run; only a non-zero nibble does.
- Digit output for idx=k:
  - If blank_in[k], or k is suppressed, or the code decodes to blank: cathodes=7'h7F.
  - Otherwise cathodes = decode(nibble k).
  - dp = ~dp_active[k], and is forced to 1 when blank_in[k].
- Decode, cathodes:
  - 0→1000000, 1→1111001, 2→0100100, 3→0110000, 4→0011001
  - 5→0010010, 6→0000010, 7→1111000, 8→0000000, 9→0010000
  - A→0001000, b→0000011, C→1000110, d→0100001, E→0000110, F→0001110
- Anodes:
  - anodes[k]=0 only when idx=k and cnt ≥ GUARD; all other bits are 1.
  - During the guard interval, all anodes are 1 and cathodes/dp are already driven for the new digit.

## Timing
- All outputs are registered and update on the rising clk edge after the cnt/idx values that produce them.
- Reset (asynchronous assert, synchronous release on the first clk):
  - cnt=0, idx=0, pend=0.
  - Active data all 4'hF, active dp all 0, active blank all 1.
  - anodes all 1, cathodes=7'h7F, dp=1, frame_done=0.
- Frame period is DIGITS*DIV cycles; each digit is lit DIV-GUARD cycles per frame.
- Load-to-display latency:
  - Between 1 and DIGITS*DIV cycles, up to the next wrap.
  - The first digit-0 slot after the wrap shows the new value (after the one-cycle output register).
- Reset asserted mid-frame takes effect immediately. The pending set is discarded and the display is dark until the first post-reset load has been transferred at a wrap.
- DIGITS=1: idx stays 0; every slot end is a wrap and pulses frame_done.

## Test plan
- Reset release, no load, DIGITS=4, DIV=4, GUARD=1 → anodes stay 4'hF throughout, frame_done pulses every 16 cycles, cathodes=7'h7F.
- load data_in=16'h1234, dp_in=4'b0100, lz_en=0 → after the next wrap:
  - the digit slots are on anodes 1110, 1101, 1011, 0111 in turn, each low for 3 of its 4 cycles;
  - cathodes are 0011001, 0110000, 0100100, 1111001;
  - dp=0 only in the digit-2 slot.
- load 16'h0070 with lz_en=1 → digits 3 and 2 are dark (7F), digit 1 = 1111000, digit 0 = 1000000. Load 16'h0000 → only digit 0 is lit, showing 1000000.
- HEX=0 then HEX=1 with data 16'hABCD → HEX=0 shows 7F, 7F, 7F, 0100001; HEX=1 shows 0001000, 0000011, 1000110, 0100001.
- Load on a non-wrap cycle and again on the exact wrap cycle with a different value → the active set changes once, at the wrap, to the second value; no mid-frame change.
- Load, then assert rst_n=0 for 2 cycles in the middle of a digit-2 slot → outputs return to reset values asynchronously, and the old pending data never appears.
